// File: rtl/spi_master.sv
// SPI master, mode 0 (sclk idles low, data sampled on rising sclk), MSB first.
// One 8-bit transfer per accepted start. The frame is SETUP, SHIFT and HOLD, and
// cs_n stays low for 18*CLK_DIV clock_in cycles. done pulses for one cycle when
// the frame ends.
// Optional build macro SPI_MASTER_LOOPBACK_EN: the receive path samples the
// internal mosi bit instead of the miso pin. The external pins are unchanged.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Last divider count of a phase; every phase lasts CLK_DIV cycles.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_sclk;

  logic       w_phase_end;
  logic       w_accept;
  logic       w_rise;
  logic       w_fall;
  logic       w_active;
  logic       w_mosi;
  logic       w_rx_bit;

  assign w_phase_end = (r_div == DIV_LAST);
  // A new request is taken while idle and also in the DONE cycle. This allows
  // back-to-back frames with cs_n high for exactly one cycle.
  assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_active    = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
  // mosi shows the top of the shift register during the frame. It drives 0 otherwise.
  assign w_mosi      = w_active ? r_tx_shift[7] : 1'b0;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic w_unused_miso;
  assign w_unused_miso = miso;
  assign w_rx_bit      = w_mosi;
`else
  assign w_rx_bit      = miso;
`endif

  assign busy    = w_active;
  assign done    = (r_state == ST_DONE);
  assign cs_n    = ~w_active;
  assign sclk    = r_sclk;
  assign mosi    = w_mosi;
  assign rx_data = r_rx_data;

  // State register; reset returns to IDLE immediately and aborts any frame.
  always_ff @(posedge clock_in) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and the sclk edge strobes for this cycle.
  always_comb begin
    w_state_next = r_state;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_SETUP;
      end
      ST_SETUP: begin
        // Leaving SETUP raises sclk for the first bit.
        if (w_phase_end) begin
          w_state_next = ST_SHIFT;
          w_rise       = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_phase_end) begin
          if (r_sclk) begin
            w_fall = 1'b1;
          end else if (r_bit == 3'd0) begin
            // The low phase of bit 0 is complete, so do not start a ninth bit.
            w_state_next = ST_HOLD;
          end else begin
            w_rise = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (w_phase_end) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = start ? ST_SETUP : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: divider, bit counter, sclk, both shift registers and the rx result.
  always_ff @(posedge clock_in) begin
    if (!rst_n) begin
      r_div      <= 8'd0;
      r_bit      <= 3'd0;
      r_tx_shift <= 8'd0;
      r_rx_shift <= 8'd0;
      r_rx_data  <= 8'd0;
      r_sclk     <= 1'b0;
    end else begin
      // The divider restarts at each state entry and at each sclk toggle.
      if ((w_state_next != r_state) || w_rise || w_fall) begin
        r_div <= 8'd0;
      end else if (w_active) begin
        r_div <= r_div + 8'd1;
      end

      if (w_accept) begin
        r_tx_shift <= tx_data;
        r_rx_shift <= 8'd0;
        r_bit      <= 3'd7;
      end

      // Rising sclk: sample the receive bit, and move to the next bit after the first.
      if (w_rise) begin
        r_sclk     <= 1'b1;
        r_rx_shift <= {r_rx_shift[6:0], w_rx_bit};
        if (r_state == ST_SHIFT) r_bit <= r_bit - 3'd1;
      end

      // Falling sclk: present the next mosi bit. Bit 0 holds until the frame ends.
      if (w_fall) begin
        r_sclk <= 1'b0;
        if (r_bit != 3'd0) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      if ((r_state == ST_HOLD) && (w_state_next == ST_DONE)) begin
        r_rx_data <= r_rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master (CLK_DIV=4). The driver predicts each frame
// from the protocol timing (18*CLK_DIV cycles of cs_n low) and pushes the
// expected result. A behavioural mode-0 slave returns the requested bytes and
// records what it saw on mosi. A monitor pops and compares on every done.
module tb_spi_master;
  localparam int CD     = 4;
  localparam int XFER   = 18 * CD;
  localparam int N_RAND = 24;

  logic       clock_in = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sclk, cs_n, mosi, miso;

  spi_master #(.CLK_DIV(CD)) dut (
    .clock_in(clock_in), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int n_done = 0;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] mosi_q[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Behavioural mode-0 slave. It loads its reply when cs_n falls and shifts it
  // out on falling sclk. It collects mosi on rising sclk and reports a
  // complete byte when cs_n rises.
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  int         sl_cnt = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;

  always @(cs_n or sclk) begin
    if (cs_n !== prev_cs) begin
      if (cs_n == 1'b0) begin
        sl_tx  = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
        sl_cnt = 0;
      end else if (sl_cnt == 8) begin
        mosi_q.push_back(sl_rx);
      end
    end else if (!cs_n && (sclk !== prev_sclk)) begin
      if (sclk) begin
        sl_rx  = {sl_rx[6:0], mosi};
        sl_cnt = sl_cnt + 1;
      end else begin
        sl_tx = {sl_tx[6:0], 1'b0};
      end
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

`ifdef SPI_MASTER_LOOPBACK_EN
  assign miso = 1'b0;
`else
  assign miso = sl_tx[7];
`endif

  // Monitor: every done pulse must match the oldest outstanding frame.
  always @(negedge clock_in) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        logic [7:0] seen;
        e = exp_q.pop_front();
        seen = (mosi_q.size() > 0) ? mosi_q.pop_front() : ~e.tx;
        $display("xfer %0d: tx=%02h rx=%02h (exp %02h) mosi=%02h done_cycle=%0d (exp %0d)",
                 n_done, e.tx, rx_data, e.rx, seen, cyc, e.done_cyc);
        n_done++;
        chk("rx_data", rx_data, e.rx);
        chk("done_cycle", cyc, e.done_cyc);
        chk("mosi_byte", seen, e.tx);
        chk("busy_in_done", busy, 0);
        chk("cs_n_in_done", cs_n, 1);
      end
    end
  end

  // Issue one frame in the current cycle, which the caller knows the DUT can accept.
  // hold keeps start high through the frame so that the next frame follows
  // back-to-back. inj pulses an ignored start with tx_data=FF at t0+inj.
  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sb, input bit hold, input int inj);
    int t0;
    exp_t e;
    t0 = cyc;
    start = 1'b1;
    tx_data = tx;
    slave_q.push_back(sb);
    e.tx = tx;
`ifdef SPI_MASTER_LOOPBACK_EN
    e.rx = tx;
`else
    e.rx = sb;
`endif
    e.done_cyc = t0 + 1 + XFER;
    exp_q.push_back(e);
    @(negedge clock_in);
    while (cyc < t0 + 1 + XFER) begin
      start   = hold || (cyc == t0 + inj);
      tx_data = (cyc == t0 + inj) ? 8'hFF : 8'($urandom);
      @(negedge clock_in);
    end
    if (!hold) start = 1'b0;
  endtask

  // Start a frame and assert reset just after the third rising sclk.
  task automatic reset_abort();
    int   rises;
    int   guard;
    logic prev;
    rises = 0;
    guard = 0;
    start = 1'b1;
    tx_data = 8'($urandom);
    slave_q.push_back(8'($urandom));
    @(negedge clock_in);
    start = 1'b0;
    prev = sclk;
    while (rises < 3 && guard < 20 * CD) begin
      @(negedge clock_in);
      guard++;
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    chk("abort_third_sclk_seen", rises, 3);
    rst_n = 1'b0;
    @(negedge clock_in);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rx_data", rx_data, 0);
    rst_n = 1'b1;
    repeat (XFER + 4) @(negedge clock_in);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold;
    // Reset with start asserted: nothing may be accepted.
    rst_n = 1'b0;
    start = 1'b1;
    tx_data = 8'h77;
    repeat (3) begin
      @(negedge clock_in);
      chk("reset_cs_n", cs_n, 1);
      chk("reset_sclk", sclk, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_mosi", mosi, 0);
      chk("reset_rx_data", rx_data, 0);
    end
    // The first cycle out of reset accepts the A9 frame. An ignored FF request follows at T+10.
    rst_n = 1'b1;
    run_xfer(8'hA9, 8'h5C, 1'b0, 10);
    repeat (3) @(negedge clock_in);

    // start held high continuously: two back-to-back frames.
    run_xfer(8'h12, 8'hA5, 1'b1, 0);
    run_xfer(8'h34, 8'hC3, 1'b0, 0);
    repeat (2) @(negedge clock_in);

    reset_abort();

    for (int i = 0; i < N_RAND; i++) begin
      hold = (i < N_RAND - 1) && ($urandom_range(0, 2) == 0);
      run_xfer(8'($urandom), 8'($urandom), hold, int'($urandom_range(2, XFER)));
      if (!hold) repeat ($urandom_range(1, 3)) @(negedge clock_in);
    end

    repeat (10) @(negedge clock_in);
    chk("pending_frames", exp_q.size(), 0);
    chk("done_count", n_done, N_RAND + 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clock_in cycles per SCLK half-period, legal range 1..255.
REQ-002 SHALL have port clock_in  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request one 8-bit transfer; sampled only when busy=0.
REQ-005 SHALL have port tx_data  input  8  byte to send; captured in the cycle start is accepted.
REQ-006 SHALL have port rx_data  output  8  last received byte; updated only in the done cycle.
REQ-007 SHALL have port busy  output  1  high from the cycle after acceptance through the last HOLD cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse at end of transfer.
REQ-009 SHALL have port sclk  output  1  SPI clock, mode 0 (idle low).
REQ-010 SHALL have port cs_n  output  1  chip select, active-low.
REQ-011 SHALL have port mosi  output  1  serial data out, MSB first.
REQ-012 SHALL have port miso  input  1  serial data in, MSB first.

Function
REQ-013 SHALL implement states IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-014 IDLE: sclk=0, cs_n=1, busy=0; start=1 -> capture tx_data into shift reg, go SETUP next cycle.
REQ-015 SETUP: cs_n=0, mosi=tx_data[7], sclk=0, busy=1, for exactly CLK_DIV cycles, then SHIFT.
REQ-016 SHIFT: 8 SCLK periods, each = CLK_DIV cycles sclk=1 then CLK_DIV cycles sclk=0.
REQ-017 SHIFT: miso SHALL be sampled on the clock_in edge that drives sclk 0->1; bit order MSB first.
REQ-018 SHIFT: mosi SHALL advance to next bit on the edge that drives sclk 1->0, except after bit 0 (mosi holds bit 0).
REQ-019 Bit counter 3 bits, counts 7 down to 0; SHIFT exits after 8th falling sclk edge, never wraps into a 9th bit.
REQ-020 HOLD: sclk=0, cs_n=0 for CLK_DIV cycles, then DONE.
REQ-021 DONE: one cycle, cs_n=1, busy=0, done=1, rx_data <= received byte; then IDLE.
REQ-022 start in DONE cycle SHALL be accepted (back-to-back, cs_n high exactly 1 cycle between transfers).
REQ-023 start while busy=1 SHALL be ignored; tx_data changes while busy SHALL not affect the transfer.
REQ-024 Latency: start accepted at cycle T -> cs_n falls at T+1, done=1 at T+1+18*CLK_DIV; cs_n low 18*CLK_DIV cycles.
REQ-025 Divider counter SHALL reset to 0 at every state entry and at every sclk toggle; no free-running divider.

Reset
REQ-026 rst_n=0 at rising clock_in SHALL force: state IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=8'h00, counters 0.
REQ-027 Reset mid-transfer SHALL abort within one cycle (cs_n=1, sclk=0), no done pulse, rx_data=8'h00.
REQ-028 start asserted during reset SHALL be ignored; first acceptance is the first cycle with rst_n=1.

Configuration
REQ-029 Macro SPI_MASTER_LOOPBACK_EN defined: receive path SHALL sample internal mosi instead of miso (rx_data == transmitted byte); sclk/cs_n/mosi pins unchanged.
REQ-030 Macro SPI_MASTER_LOOPBACK_EN undefined: receive path SHALL sample miso; no loopback logic present.

Verification
REQ-031 CLK_DIV=4, tx_data=8'hA9, slave model returns 8'h5C -> mosi bits 1,0,1,0,1,0,0,1 at rising sclk; rx_data=8'h5C; done at T+73.
REQ-032 start pulsed again at T+10 during transfer with tx_data=8'hFF -> ignored, mosi still 8'hA9 pattern, exactly one done.
REQ-033 start held high continuously, tx_data 8'h12 then 8'h34 -> two transfers, cs_n high exactly 1 cycle between, rx_data per slave each.
REQ-034 rst_n=0 after 3rd rising sclk edge -> next cycle cs_n=1, sclk=0, busy=0, rx_data=8'h00, no done pulse.
REQ-035 CLK_DIV=1, tx_data=8'h80, miso tied 1 -> sclk period 2 cycles, rx_data=8'hFF, done at T+19.
REQ-036 SPI_MASTER_LOOPBACK_EN defined, miso tied 0, tx_data=8'h3C -> rx_data=8'h3C.
